// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter for two requesters in front of a registered 8-op ALU
module alu_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [2:0]       req0_op,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_y,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t           state_q, state_d;
   logic             ptr_q, ptr_d, id_q, id_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
   logic             carry_q, carry_d, zero_q, zero_d;
   logic             grant1, accept;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] alu_y;
   logic             alu_c;
   assign grant1     = req1_valid & (~req0_valid | ptr_q);
   assign accept     = (state_q == IDLE) & ~rst & (req0_valid | req1_valid);
   assign req0_ready = accept & ~grant1;
   assign req1_ready = accept & grant1;
   assign sum        = {1'b0, a_q} + {1'b0, b_q};
   assign diff       = {1'b0, a_q} - {1'b0, b_q};
   assign rsp_valid  = state_q == RESP;
   assign busy       = state_q != IDLE;
   assign rsp_id     = id_q;
   assign rsp_y      = y_q;
   assign rsp_carry  = carry_q;
   assign rsp_zero   = zero_q;
   // ALU on the captured operands; carry doubles as borrow for SUB
   always_comb begin
      alu_y = '0;
      alu_c = 1'b0;
      case (op_q)
         3'b000: {alu_c, alu_y} = sum;
         3'b001: {alu_c, alu_y} = diff;
         3'b010: alu_y = a_q & b_q;
         3'b011: alu_y = a_q | b_q;
         3'b100: alu_y = a_q ^ b_q;
         3'b101: alu_y = ~a_q;
         3'b110: {alu_c, alu_y} = {a_q, 1'b0};
         3'b111: {alu_y, alu_c} = {1'b0, a_q};
      endcase
   end
   // next state: capture on acceptance, register result leaving EXEC, release on handshake
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      y_d     = y_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = EXEC;
            id_d    = grant1;
            ptr_d   = ~grant1;
            op_d    = grant1 ? req1_op : req0_op;
            a_d     = grant1 ? req1_a : req0_a;
            b_d     = grant1 ? req1_b : req0_b;
         end
         EXEC: begin
            state_d = RESP;
            y_d     = alu_y;
            carry_d = alu_c;
            zero_d  = ~|alu_y;
         end
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state register with synchronous reset that aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         y_q     <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         y_q     <= y_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table and sequence checks for alu_arbiter
module tb_alu_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic       rsp_valid, rsp_id, rsp_carry, rsp_zero, busy;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_y;
   int         pass_n = 0, total_n = 0;

   typedef struct {
      logic       id;
      logic [2:0] op;
      logic [7:0] a, b, y;
      logic       c, z;
   } vec_t;
   vec_t v[10];

   alu_arbiter #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_op(req0_op), .req1_op(req1_op),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rst_ready0", {31'b0, req0_ready}, 0);
      chk("rst_ready1", {31'b0, req1_ready}, 0);
      @(negedge clk);
      chk("rst_outputs", {24'b0, rsp_valid, busy, rsp_id, rsp_carry, rsp_zero, 3'b0}, 0);
      chk("rst_y", {24'b0, rsp_y}, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic start(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
      #1;
      chk("accept_ready0", {31'b0, req0_ready}, {31'b0, ~id});
      chk("accept_ready1", {31'b0, req1_ready}, {31'b0, id});
      @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = ~req0_a; req0_b = ~req0_b; req0_op = ~req0_op;
      req1_a = ~req1_a; req1_b = ~req1_b; req1_op = ~req1_op;
   endtask

   task automatic expect_rsp(input logic id, input logic [7:0] y, input logic c, input logic z);
      @(negedge clk);
      chk("exec_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("exec_busy", {31'b0, busy}, 1);
      @(negedge clk);
      chk("rsp_valid", {31'b0, rsp_valid}, 1);
      chk("rsp_id", {31'b0, rsp_id}, {31'b0, id});
      chk("rsp_y", {24'b0, rsp_y}, {24'b0, y});
      chk("rsp_carry", {31'b0, rsp_carry}, {31'b0, c});
      chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, z});
   endtask

   initial begin
      v[0] = '{1'b0, 3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
      v[1] = '{1'b0, 3'b000, 8'hA5, 8'h0F, 8'hB4, 1'b0, 1'b0};
      v[2] = '{1'b0, 3'b001, 8'hA5, 8'h0F, 8'h96, 1'b0, 1'b0};
      v[3] = '{1'b0, 3'b010, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0};
      v[4] = '{1'b0, 3'b011, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0};
      v[5] = '{1'b0, 3'b100, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0};
      v[6] = '{1'b0, 3'b101, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0};
      v[7] = '{1'b0, 3'b110, 8'hA5, 8'h0F, 8'h4A, 1'b1, 1'b0};
      v[8] = '{1'b0, 3'b111, 8'hA5, 8'h0F, 8'h52, 1'b1, 1'b0};
      v[9] = '{1'b0, 3'b001, 8'h03, 8'h04, 8'hFF, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         start(v[i].id, v[i].op, v[i].a, v[i].b);
         expect_rsp(v[i].id, v[i].y, v[i].c, v[i].z);
         @(negedge clk);
         chk("back_to_idle", {31'b0, busy}, 0);
      end
      do_reset();
      req0_valid = 1'b1; req0_op = 3'b001; req0_a = 8'h05; req0_b = 8'h05;
      req1_valid = 1'b1; req1_op = 3'b001; req1_a = 8'h05; req1_b = 8'h05;
      for (int k = 0; k < 4; k++) begin
         int n = 0;
         #1;
         while (!(req0_ready || req1_ready) && n < 6) begin
            @(negedge clk);
            #1;
            n++;
         end
         chk("grant_timeout", {31'b0, n < 6}, 1);
         chk("rr_ready0", {31'b0, req0_ready}, {31'b0, ~k[0]});
         chk("rr_ready1", {31'b0, req1_ready}, {31'b0, k[0]});
         @(posedge clk);
         expect_rsp(k[0], 8'h00, 1'b0, 1'b1);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("rr_idle", {31'b0, busy}, 0);
      rsp_ready = 1'b0;
      start(1'b1, 3'b110, 8'h81, 8'h00);
      expect_rsp(1'b1, 8'h02, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", {31'b0, rsp_valid}, 1);
         chk("hold_id", {31'b0, rsp_id}, 1);
         chk("hold_y", {24'b0, rsp_y}, 8'h02);
         chk("hold_carry", {31'b0, rsp_carry}, 1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_busy", {31'b0, busy}, 0);
      chk("hold_release_valid", {31'b0, rsp_valid}, 0);
      start(1'b0, 3'b000, 8'h01, 8'h02);
      @(negedge clk);
      chk("abort_in_exec", {31'b0, busy}, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_valid", {31'b0, rsp_valid}, 0);
      @(negedge clk);
      chk("abort_no_rsp", {31'b0, rsp_valid}, 0);
      req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h02;
      req1_valid = 1'b1; req1_op = 3'b010; req1_a = 8'hFF; req1_b = 8'hFF;
      #1;
      chk("post_abort_ready0", {31'b0, req0_ready}, 1);
      chk("post_abort_ready1", {31'b0, req1_ready}, 0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      expect_rsp(1'b0, 8'h03, 1'b0, 1'b0);
      @(negedge clk);
      chk("final_idle", {31'b0, busy}, 0);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester 0/1 presents an operation.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: the operation is accepted this cycle.
REQ-006 The block SHALL have ports req0_op / req1_op, input, 3 bits each: operation code.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: a result is presented.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-011 The block SHALL have port rsp_y, output, WIDTH bits: result value.
REQ-012 The block SHALL have ports rsp_carry and rsp_zero, output, 1 bit each: result flags.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and RESP; transitions: IDLE->EXEC on an accepted request; EXEC->RESP unconditionally; RESP->IDLE on rsp_valid&rsp_ready; otherwise hold.
REQ-015 Grant SHALL be combinational in IDLE: if exactly one valid, grant it; if both valid, grant the requester named by the priority pointer.
REQ-016 reqX_ready SHALL be 1 only in IDLE for the granted requester, and 0 in EXEC/RESP and for the losing requester.
REQ-017 On acceptance, the operands, op and requester index SHALL be captured; the pointer SHALL point to the other requester; later input changes SHALL NOT affect the result.
REQ-018 The result SHALL be computed in EXEC and registered on the EXEC->RESP edge: rsp_valid rises 2 cycles after the accepting edge.
REQ-019 The ops SHALL be: 000 a+b; 001 a-b; 010 a&b; 011 a|b; 100 a^b; 101 ~a; 110 a<<1; 111 a>>1 (logical); results truncated to WIDTH.
REQ-020 rsp_carry SHALL be: ADD carry-out; SUB borrow (1 iff a<b unsigned); SHL a[WIDTH-1]; SHR a[0]; all other ops 0.
REQ-021 rsp_zero SHALL be 1 iff rsp_y is all zeros.
REQ-022 rsp_valid, rsp_id, rsp_y and the flags SHALL stay stable in RESP until rsp_ready is 1 (backpressure holds indefinitely).
REQ-023 No request SHALL be accepted in the cycle of the RESP->IDLE transition; the next acceptance is at the earliest one cycle later, giving a minimum of 3 cycles per operation.
REQ-024 A requester that loses arbitration SHALL keep valid asserted.
REQ-025 The block SHALL NOT drop or reorder a held request, and SHALL NOT let any requester wait more than one other operation (round-robin fairness).

Reset
REQ-026 While rst is 1 at a clock edge, the block SHALL enter IDLE; the pointer SHALL select requester 0; rsp_valid, busy, rsp_id, rsp_y, rsp_carry and rsp_zero SHALL be 0.
REQ-027 A reset asserted in EXEC or RESP SHALL abort the operation with no response issued, and both reqX_ready SHALL be 0 during reset.

Verification
REQ-028 The bench SHALL cover: after reset, req0 only, ADD a=8'hF0 b=8'h20 -> req0_ready=1 at cycle 0, rsp_valid at cycle 2, rsp_y=8'h10, carry=1, zero=0, rsp_id=0.
REQ-029 The bench SHALL cover: both requesters valid from reset, each issuing SUB 8'h05-8'h05 with rsp_ready tied 1 -> grants alternate 0,1,0,1; each rsp_y=0, zero=1, carry=0.
REQ-030 The bench SHALL cover: req1 SHL a=8'h81 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_y=8'h02, carry=1, stable until rsp_ready rises; then IDLE next cycle.
REQ-031 The bench SHALL cover: req0 SUB a=8'h03 b=8'h04 with operands changed after acceptance -> rsp_y=8'hFF, carry=1, computed from the captured values.
REQ-032 The bench SHALL cover: rst pulsed while in EXEC -> no rsp_valid; busy=0; the next simultaneous request grants requester 0.
REQ-033 The bench SHALL cover: all 8 ops on req0 with a=8'hA5 b=8'h0F -> 0xB4, 0x96, 0x05, 0xAF, 0xAA, 0x5A, 0x4A (carry 1), 0x52 (carry 1).
